// File: rtl/game_score_counter.sv
// game_score_counter
//
// Score counter for the game datapath. Counts player hits up or down, supports
// a parallel load and a round clear, and either wraps or saturates at a
// programmable terminal count. A best-score register follows the count upward
// and survives round clears; only reset lowers it.
//
// Parameters:
//   CNT_W    internal count width (1..16)
//   OUT_W    width of the score/best output buses (>= CNT_W), zero-filled
//   MAX_VAL  terminal count (1 .. 2^CNT_W-1)
//   SATURATE 0 = wrap between MAX_VAL and 0, 1 = hold at MAX_VAL / 0
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-low reset
//   clr      round clear of the count (best is kept)
//   ld       parallel load strobe, din clamped to MAX_VAL
//   din      load value
//   up, dw   level-sensitive increment / decrement requests
//   score    zero-extended count
//   best     zero-extended best count
//   at_max   count == MAX_VAL
//   at_zero  count == 0
//   wrap     one-cycle pulse after an edge that wrapped the count
//   changed  one-cycle pulse after an edge that changed the count
module game_score_counter #(
  parameter int CNT_W    = 6,
  parameter int OUT_W    = 8,
  parameter int MAX_VAL  = 63,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] din,
  input  logic             up,
  input  logic             dw,
  output logic [OUT_W-1:0] score,
  output logic [OUT_W-1:0] best,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             changed
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             wrap_q, wrap_d;
  logic             changed_q, changed_d;

  // Next-count selection. Counting is modulo MAX_VAL+1, so the terminal
  // values are compared explicitly rather than relying on binary overflow.
  // Pulses are derived from the next count so they appear together with it.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (ld) begin
      count_d = (din > MAX_C) ? MAX_C : din;
    end else if (up && !dw) begin
      if (count_q == MAX_C) begin
        if (SATURATE == 0) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = count_q + ONE_C;
      end
    end else if (dw && !up) begin
      if (count_q == '0) begin
        if (SATURATE == 0) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = count_q - ONE_C;
      end
    end
    changed_d = (count_d != count_q);
    // Best follows the next count on the same edge so it never lags score.
    best_d = (count_d > best_q) ? count_d : best_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      best_q    <= '0;
      wrap_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      best_q    <= best_d;
      wrap_q    <= wrap_d;
      changed_q <= changed_d;
    end
  end

  // Zero extension by cast also covers OUT_W == CNT_W with no pad bits.
  assign score   = OUT_W'(count_q);
  assign best    = OUT_W'(best_q);
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);
  assign wrap    = wrap_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_game_score_counter.sv
// Bench for game_score_counter. Three instances share one stimulus stream:
//   0: defaults (wrap at 63)
//   1: CNT_W=4, OUT_W=4, MAX_VAL=9, SATURATE=1 (no pad bits)
//   2: MAX_VAL=40, wrapping
// A behavioural model per instance pushes expected outputs into a queue as
// stimulus is driven; they are popped and compared one edge later.
module tb_game_score_counter;

  typedef struct {
    int inst;
    int score;
    int best;
    int atMax;
    int atZero;
    int wrap;
    int changed;
  } expT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [5:0] din = '0;
  logic       up = 1'b0;
  logic       dw = 1'b0;

  logic [7:0] score0, best0, score2, best2;
  logic [3:0] score1, best1;
  logic       atMax0, atZero0, wrap0, changed0;
  logic       atMax1, atZero1, wrap1, changed1;
  logic       atMax2, atZero2, wrap2, changed2;

  int checkCount = 0;
  int errorCount = 0;

  int maxVal[3]  = '{63, 9, 40};
  int satCfg[3]  = '{0, 1, 0};
  int dinMask[3] = '{63, 15, 63};
  int modelCount[3];
  int modelBest[3];

  expT expQ[$];

  always #5 clk = ~clk;

  game_score_counter dut0 (
    .clk(clk), .reset(reset), .clr(clr), .ld(ld), .din(din), .up(up), .dw(dw),
    .score(score0), .best(best0), .at_max(atMax0), .at_zero(atZero0),
    .wrap(wrap0), .changed(changed0)
  );

  game_score_counter #(.CNT_W(4), .OUT_W(4), .MAX_VAL(9), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .ld(ld), .din(din[3:0]), .up(up), .dw(dw),
    .score(score1), .best(best1), .at_max(atMax1), .at_zero(atZero1),
    .wrap(wrap1), .changed(changed1)
  );

  game_score_counter #(.MAX_VAL(40)) dut2 (
    .clk(clk), .reset(reset), .clr(clr), .ld(ld), .din(din), .up(up), .dw(dw),
    .score(score2), .best(best2), .at_max(atMax2), .at_zero(atZero2),
    .wrap(wrap2), .changed(changed2)
  );

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advances the model of instance i by one edge and queues what it should show.
  task automatic modelEdge(input int i, input logic rst, input logic c, input logic l,
                           input int d, input logic u, input logic w);
    expT e;
    int prev, nxt, wr, dv;
    prev = modelCount[i];
    nxt  = prev;
    wr   = 0;
    dv   = d & dinMask[i];
    if (!rst) begin
      modelCount[i] = 0;
      modelBest[i]  = 0;
      e = '{i, 0, 0, 0, 1, 0, 0};
    end else begin
      if (c) nxt = 0;
      else if (l) nxt = (dv > maxVal[i]) ? maxVal[i] : dv;
      else if (u && !w) begin
        if (satCfg[i] != 0) nxt = (prev < maxVal[i]) ? prev + 1 : prev;
        else begin
          nxt = (prev + 1) % (maxVal[i] + 1);
          wr  = (prev == maxVal[i]) ? 1 : 0;
        end
      end else if (w && !u) begin
        if (satCfg[i] != 0) nxt = (prev > 0) ? prev - 1 : prev;
        else begin
          nxt = (prev + maxVal[i]) % (maxVal[i] + 1);
          wr  = (prev == 0) ? 1 : 0;
        end
      end
      modelCount[i] = nxt;
      if (nxt > modelBest[i]) modelBest[i] = nxt;
      e = '{i, nxt, modelBest[i], (nxt == maxVal[i]) ? 1 : 0, (nxt == 0) ? 1 : 0,
            wr, (nxt != prev) ? 1 : 0};
    end
    expQ.push_back(e);
  endtask

  // Pops one expected entry and compares it to the matching instance.
  task automatic compareNext();
    expT e;
    int s, b, am, az, wr, ch;
    e = expQ.pop_front();
    case (e.inst)
      0: begin s = score0; b = best0; am = atMax0; az = atZero0; wr = wrap0; ch = changed0; end
      1: begin s = score1; b = best1; am = atMax1; az = atZero1; wr = wrap1; ch = changed1; end
      default: begin s = score2; b = best2; am = atMax2; az = atZero2; wr = wrap2; ch = changed2; end
    endcase
    checkOutput($sformatf("dut%0d score", e.inst), s, e.score);
    checkOutput($sformatf("dut%0d best", e.inst), b, e.best);
    checkOutput($sformatf("dut%0d at_max", e.inst), am, e.atMax);
    checkOutput($sformatf("dut%0d at_zero", e.inst), az, e.atZero);
    checkOutput($sformatf("dut%0d wrap", e.inst), wr, e.wrap);
    checkOutput($sformatf("dut%0d changed", e.inst), ch, e.changed);
  endtask

  // Drives one cycle of inputs, queues expectations, then checks after the edge.
  task automatic applyStimulus(input logic rst, input logic c, input logic l,
                               input int d, input logic u, input logic w);
    reset = rst; clr = c; ld = l; din = 6'(d); up = u; dw = w;
    for (int i = 0; i < 3; i++) modelEdge(i, rst, c, l, d, u, w);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) compareNext();
  endtask

  initial begin
    // Reset held with competing requests.
    applyStimulus(0, 0, 1, 5, 1, 0);
    applyStimulus(0, 0, 1, 5, 1, 0);
    // First count after release.
    applyStimulus(1, 0, 0, 0, 1, 0);
    // Load near the top, count through the wrap, then wrap downward.
    applyStimulus(1, 0, 1, 62, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    // Back-to-back wraps.
    applyStimulus(1, 0, 1, 63, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 0);
    // Clear, then long runs up and down.
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) applyStimulus(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) applyStimulus(1, 0, 0, 0, 0, 1);
    // Load clamp with up, then clear beating load.
    applyStimulus(1, 0, 1, 50, 1, 0);
    applyStimulus(1, 1, 1, 50, 0, 0);
    // Simultaneous up and down hold.
    applyStimulus(1, 0, 1, 20, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 1, 1);
    // Reset in the middle of counting.
    applyStimulus(1, 0, 1, 29, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 1, 0);
    // Random mix with occasional clear and load.
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/game_score_counter.md
Name: game_score_counter

Overview:
Parametrised score counter for the game datapath: counts player hits up or down, supports parallel load and clear, and selects wrap or saturate at a programmable maximum. It also keeps a best-score register that survives round clears. It drives the score display path directly with a zero-extended output bus, and flags terminal conditions to the game FSM.

Parameters:
CNT_W, 6, internal count width in bits (1..16)
OUT_W, 8, width of score/best output buses; must be >= CNT_W; upper bits zero-filled
MAX_VAL, 63, terminal count; must be <= 2^CNT_W-1 and >= 1
SATURATE, 0, 0 = wrap at MAX_VAL/0, 1 = hold at MAX_VAL/0

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
clr  input  1  synchronous round clear of count (best kept)
ld  input  1  parallel load strobe
din  input  CNT_W  load value
up  input  1  increment request, level-sensitive, one step per cycle
dw  input  1  decrement request, level-sensitive, one step per cycle
score  output  OUT_W  {zeros, count}
best  output  OUT_W  {zeros, best_count}
at_max  output  1  count == MAX_VAL (combinational from count register)
at_zero  output  1  count == 0 (combinational from count register)
wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge
changed  output  1  registered one-cycle pulse: count value differs from previous cycle

Behaviour:
- One clock; reset is synchronous and active-low; sampled only on rising clk.
- Reset (reset=0): count=0, best_count=0, wrap=0, changed=0; so score=0, best=0, at_zero=1, at_max=0. Overrides all other inputs.
- Priority per edge when reset=1: clr > ld > (up XOR dw) > hold.
- clr=1: count<=0; best unchanged; changed=1 if previous count != 0.
- ld=1: count<=min(din, MAX_VAL); values above MAX_VAL clamp to MAX_VAL; no wrap pulse.
- up=1 and dw=1 together (no clr/ld): hold, no pulses.
- up only: count<MAX_VAL -> count+1. count==MAX_VAL: SATURATE=0 -> count<=0, wrap<=1; SATURATE=1 -> hold, wrap<=0.
- dw only: count>0 -> count-1. count==0: SATURATE=0 -> count<=MAX_VAL, wrap<=1; SATURATE=1 -> hold.
- Increment/decrement are modulo MAX_VAL+1, not modulo 2^CNT_W; count never exceeds MAX_VAL.
- wrap and changed are registered: high for exactly the cycle after the edge that caused them; otherwise 0. Back-to-back wraps give consecutive pulses.
- best_count: on each edge, if next count > best_count, best_count<=next count (same edge, no extra latency). Never decreases except on reset. A wrap to 0 does not lower best.
- Latency: score reflects a request one clock after it is sampled; best tracks score with the same timing.
- Reset asserted mid-count wins immediately at the next edge regardless of up/dw/ld/clr.
- Output zero-extension: score[OUT_W-1:CNT_W] = 0 at all times (incl. OUT_W == CNT_W degenerate case: no pad).

Test Plan:
- Reset: hold reset=0 for 2 cycles with up=1, ld=1, din=5 -> score=0, best=0, at_zero=1, wrap=0, changed=0; release -> first up edge gives score=1, changed pulse.
- Wrap up (defaults): load 62, up for 3 cycles -> score 63 (at_max=1), 0 (wrap pulse one cycle, best=63), 1; dw at 0 -> 63 with wrap pulse.
- Saturate (SATURATE=1, MAX_VAL=9): up for 12 cycles from 0 -> score stops at 9, at_max=1, wrap never asserts; dw 12 cycles -> stops at 0, at_zero=1.
- Load clamp and priority (MAX_VAL=40): din=50 with ld=1 and up=1 -> score=40, best=40; next cycle clr=1 with ld=1 -> score=0, best stays 40.
- Simultaneous up and dw: count=20, up=dw=1 for 4 cycles -> score stays 20, changed=0, wrap=0.
- Reset mid-operation: counting up at score=30, best=30, assert reset=0 for one edge with up=1 -> score=0, best=0, no pulses; deassert -> counting resumes from 0.
